lvl_state_ctrl: RTL and testbench

Sequencer that sits directly upstream of the `lvl_state8` level-state chain in the SAT engine.
- Owns the current decision level and stamps each decision into the chain.
- On a conflict, drives `max_lvl` into the chain's find-backtrack-level search, waits for the combinational ripple to settle, then latches the result.
- Issues `apply_bkt` and reports the backtrack target (level, bin) to conflict analysis with a valid/done handshake.

---
 rtl/lvl_state_ctrl.sv | 110 +++++++++++
 tb/tb_lvl_state_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lvl_state_ctrl.sv
// lvl_state_ctrl: decision-level sequencer and backtrack handshake for the lvl_state8 chain
// Optional LVL_STATE_CTRL_BKT_CNT_EN adds a saturating 32-bit count of apply_bkt_o pulses.
module lvl_state_ctrl #(
  parameter int NUM_LVLS      = 8,
  parameter int WIDTH_LVL     = 16,
  parameter int WIDTH_BIN_ID  = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dcd_valid_i,
  output logic                    dcd_ready_o,
  input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
  output logic                    valid_from_decision_o,
  output logic [WIDTH_BIN_ID-1:0] cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]    cur_lvl_o,
  output logic                    lvl_full_o,
  input  logic                    bkt_req_i,
  input  logic [WIDTH_LVL-1:0]    max_lvl_i,
  output logic [WIDTH_LVL-1:0]    max_lvl_o,
  output logic [1:0]              findflag_left_o,
  input  logic [1:0]              findflag_left_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
  output logic                    apply_bkt_o,
  output logic                    bkt_done_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic                    bkt_cross_bin_o,
`ifdef LVL_STATE_CTRL_BKT_CNT_EN
  output logic [31:0]             bkt_cnt_o,
`endif
  output logic                    no_bkt_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, APPLY} state_t;
  state_t state;
  logic [3:0] cnt;
  assign findflag_left_o = 2'd0;
  assign lvl_full_o = cur_lvl_o == WIDTH_LVL'(NUM_LVLS - 1);
  // The chain sees max_lvl_o from the cycle after acceptance, so SETTLE lasts
  // SETTLE_CYCLES-1 cycles and CHECK samples the ripple on the last settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      dcd_ready_o           <= 1'b1;
      valid_from_decision_o <= 1'b0;
      cur_bin_num_o         <= '0;
      cur_lvl_o             <= '0;
      max_lvl_o             <= '0;
      apply_bkt_o           <= 1'b0;
      bkt_done_o            <= 1'b0;
      bkt_lvl_o             <= '0;
      bkt_bin_o             <= '0;
      bkt_cross_bin_o       <= 1'b0;
      no_bkt_o              <= 1'b0;
`ifdef LVL_STATE_CTRL_BKT_CNT_EN
      bkt_cnt_o             <= '0;
`endif
    end else begin
      valid_from_decision_o <= 1'b0;
      apply_bkt_o           <= 1'b0;
      bkt_done_o            <= 1'b0;
      case (state)
        IDLE: begin
          if (bkt_req_i) begin
            max_lvl_o       <= (max_lvl_i > cur_lvl_o) ? cur_lvl_o : max_lvl_i;
            cnt             <= 4'(SETTLE_CYCLES - 1);
            no_bkt_o        <= 1'b0;
            bkt_cross_bin_o <= 1'b0;
            dcd_ready_o     <= 1'b0;
            state           <= (SETTLE_CYCLES <= 1) ? CHECK : SETTLE;
          end else if (dcd_valid_i && !lvl_full_o) begin
            cur_lvl_o             <= cur_lvl_o + WIDTH_LVL'(1);
            cur_bin_num_o         <= cur_bin_num_i;
            valid_from_decision_o <= 1'b1;
          end
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= CHECK;
        end
        CHECK: begin
          if (findflag_left_i == 2'd2) begin
            bkt_lvl_o       <= bkt_lvl_i;
            bkt_bin_o       <= bkt_bin_i;
            bkt_cross_bin_o <= bkt_bin_i != cur_bin_num_i;
            state           <= APPLY;
          end else begin
            no_bkt_o    <= 1'b1;
            bkt_done_o  <= 1'b1;
            dcd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        APPLY: begin
          apply_bkt_o <= 1'b1;
          bkt_done_o  <= 1'b1;
          cur_lvl_o   <= bkt_lvl_o;
          dcd_ready_o <= 1'b1;
          state       <= IDLE;
`ifdef LVL_STATE_CTRL_BKT_CNT_EN
          if (bkt_cnt_o != '1) bkt_cnt_o <= bkt_cnt_o + 32'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lvl_state_ctrl.sv
// tb_lvl_state_ctrl: directed checks of decisions, backtrack handshake and reset abort
module tb_lvl_state_ctrl;
  logic clk = 0, rst = 1;
  logic dcd_valid_i = 0, dcd_ready_o;
  logic [9:0] cur_bin_num_i = 0, cur_bin_num_o, bkt_bin_i = 0, bkt_bin_o;
  logic valid_from_decision_o, lvl_full_o, bkt_req_i = 0;
  logic [15:0] cur_lvl_o, max_lvl_i = 0, max_lvl_o, bkt_lvl_i = 0, bkt_lvl_o;
  logic [1:0] findflag_left_o, findflag_left_i = 0;
  logic apply_bkt_o, bkt_done_o, bkt_cross_bin_o, no_bkt_o;
`ifdef LVL_STATE_CTRL_BKT_CNT_EN
  logic [31:0] bkt_cnt_o;
`endif
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lvl_state_ctrl dut (
    .clk(clk), .rst(rst), .dcd_valid_i(dcd_valid_i), .dcd_ready_o(dcd_ready_o),
    .cur_bin_num_i(cur_bin_num_i), .valid_from_decision_o(valid_from_decision_o),
    .cur_bin_num_o(cur_bin_num_o), .cur_lvl_o(cur_lvl_o), .lvl_full_o(lvl_full_o),
    .bkt_req_i(bkt_req_i), .max_lvl_i(max_lvl_i), .max_lvl_o(max_lvl_o),
    .findflag_left_o(findflag_left_o), .findflag_left_i(findflag_left_i),
    .bkt_bin_i(bkt_bin_i), .bkt_lvl_i(bkt_lvl_i), .apply_bkt_o(apply_bkt_o),
    .bkt_done_o(bkt_done_o), .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
    .bkt_cross_bin_o(bkt_cross_bin_o),
`ifdef LVL_STATE_CTRL_BKT_CNT_EN
    .bkt_cnt_o(bkt_cnt_o),
`endif
    .no_bkt_o(no_bkt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_lvl(input int n);
    rst = 1;
    step();
    rst = 0;
    cur_bin_num_i = 10'd5;
    dcd_valid_i = 1;
    repeat (n) step();
    dcd_valid_i = 0;
    chk("go_lvl", 32'(cur_lvl_o), 32'(n));
  endtask

  task automatic bkt(input logic [15:0] mx, input logic [1:0] flag, input logic [15:0] bl, input logic [9:0] bb);
    max_lvl_i = mx;
    findflag_left_i = flag;
    bkt_lvl_i = bl;
    bkt_bin_i = bb;
    bkt_req_i = 1;
    step();
    bkt_req_i = 0;
  endtask

  initial begin
    @(negedge clk);
    step();
    chk("rst_ready", 32'(dcd_ready_o), 1);
    chk("rst_lvl", 32'(cur_lvl_o), 0);
    chk("rst_valid", 32'(valid_from_decision_o), 0);
    chk("rst_full", 32'(lvl_full_o), 0);
    chk("rst_done", 32'(bkt_done_o), 0);
    chk("rst_flag_o", 32'(findflag_left_o), 0);
    rst = 0;
    cur_bin_num_i = 10'd5;
    dcd_valid_i = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("dcd_valid", 32'(valid_from_decision_o), 1);
      chk("dcd_lvl", 32'(cur_lvl_o), 32'(i));
      chk("dcd_bin", 32'(cur_bin_num_o), 5);
    end
    dcd_valid_i = 0;
    step();
    chk("dcd_idle_valid", 32'(valid_from_decision_o), 0);
    dcd_valid_i = 1;
    repeat (3) step();
    chk("lvl6_full", 32'(lvl_full_o), 0);
    step();
    chk("lvl7", 32'(cur_lvl_o), 7);
    chk("lvl7_full", 32'(lvl_full_o), 1);
    step();
    chk("full_hold_lvl", 32'(cur_lvl_o), 7);
    chk("full_no_write", 32'(valid_from_decision_o), 0);
    dcd_valid_i = 0;

    go_lvl(4);
    bkt(16'd3, 2'd2, 16'd2, 10'd5);
    chk("bk_max", 32'(max_lvl_o), 3);
    chk("bk_ready_t1", 32'(dcd_ready_o), 0);
    chk("bk_done_t1", 32'(bkt_done_o), 0);
    step();
    chk("bk_done_t2", 32'(bkt_done_o), 0);
    step();
    chk("bk_done_t3", 32'(bkt_done_o), 0);
    chk("bk_apply_t3", 32'(apply_bkt_o), 0);
    chk("bk_max_t3", 32'(max_lvl_o), 3);
    step();
    chk("bk_done_t4", 32'(bkt_done_o), 1);
    chk("bk_apply_t4", 32'(apply_bkt_o), 1);
    chk("bk_lvl_o", 32'(bkt_lvl_o), 2);
    chk("bk_bin_o", 32'(bkt_bin_o), 5);
    step();
    chk("bk_cur_lvl", 32'(cur_lvl_o), 2);
    chk("bk_done_t5", 32'(bkt_done_o), 0);
    chk("bk_apply_t5", 32'(apply_bkt_o), 0);
    chk("bk_cross", 32'(bkt_cross_bin_o), 0);
    chk("bk_no_bkt", 32'(no_bkt_o), 0);
    chk("bk_ready_t5", 32'(dcd_ready_o), 1);

    go_lvl(4);
    bkt(16'd10, 2'd2, 16'd1, 10'd9);
    chk("cr_clamp", 32'(max_lvl_o), 4);
    repeat (3) step();
    chk("cr_done", 32'(bkt_done_o), 1);
    chk("cr_cross", 32'(bkt_cross_bin_o), 1);
    chk("cr_bin", 32'(bkt_bin_o), 9);
    step();
    chk("cr_cur_lvl", 32'(cur_lvl_o), 1);
    chk("cr_cross_hold", 32'(bkt_cross_bin_o), 1);

    go_lvl(4);
    bkt(16'd3, 2'd0, 16'd2, 10'd5);
    step();
    chk("nb_done_t2", 32'(bkt_done_o), 0);
    step();
    chk("nb_done_t3", 32'(bkt_done_o), 1);
    chk("nb_flag", 32'(no_bkt_o), 1);
    chk("nb_apply_t3", 32'(apply_bkt_o), 0);
    step();
    chk("nb_apply_t4", 32'(apply_bkt_o), 0);
    chk("nb_cur_lvl", 32'(cur_lvl_o), 4);
    chk("nb_hold", 32'(no_bkt_o), 1);

    dcd_valid_i = 1;
    bkt(16'd2, 2'd2, 16'd1, 10'd5);
    dcd_valid_i = 0;
    chk("pri_lvl", 32'(cur_lvl_o), 4);
    chk("pri_no_write", 32'(valid_from_decision_o), 0);
    chk("pri_ready", 32'(dcd_ready_o), 0);
    chk("pri_clr_nobkt", 32'(no_bkt_o), 0);
    chk("pri_max", 32'(max_lvl_o), 2);
    #2 rst = 1;
    #1;
    chk("arst_lvl", 32'(cur_lvl_o), 0);
    chk("arst_max", 32'(max_lvl_o), 0);
    chk("arst_ready", 32'(dcd_ready_o), 1);
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_apply", 32'(apply_bkt_o), 0);
      chk("abort_done", 32'(bkt_done_o), 0);
    end
    chk("abort_lvl", 32'(cur_lvl_o), 0);
    chk("abort_bkt_lvl", 32'(bkt_lvl_o), 0);
    chk("abort_ready", 32'(dcd_ready_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
